// File: rtl/io_periph_pkg.sv
// Shared address map, register select encoding and byte-merge helper for the IO peripheral bank.
package io_periph_pkg;

  localparam logic [8:0] LEDR_OFF = 9'h000;
  localparam logic [8:0] LEDG_OFF = 9'h004;
  localparam logic [8:0] LCD_OFF  = 9'h008;
  localparam logic [8:0] HEX_BASE = 9'h010;
  localparam logic [8:0] SW_OFF   = 9'h100;

  typedef enum logic [2:0] {
    SEL_LEDR = 3'd0,
    SEL_LEDG = 3'd1,
    SEL_LCD  = 3'd2,
    SEL_HEX  = 3'd3,
    SEL_SW   = 3'd4,
    SEL_NONE = 3'd5
  } io_sel_e;

  // Replace only the bytes whose enable bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int n = 0; n < 4; n++) begin
      if (be[n]) begin
        res[8*n +: 8] = new_val[8*n +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/io_sw_sync.sv
// Switch input synchroniser with optional debounce filter.
// Debounce is built only when IO_SW_DEBOUNCE_EN is defined.
module io_sw_sync #(
  parameter int SW_W         = 32,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw_async,
  output logic [SW_W-1:0] sw_stable
);

  logic [SW_W-1:0] sync1_r;
  logic [SW_W-1:0] sync2_r;
  logic [SW_W-1:0] stable_r;

  // Two-flop synchroniser for the asynchronous switch pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= sw_async;
      sync2_r <= sync1_r;
    end
  end

`ifdef IO_SW_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [SW_W-1:0]  prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             load_s;

  // Count consecutive identical synced samples, saturating at DEBOUNCE_CYC.
  always_comb begin
    cnt_next_s = cnt_r;
    if (sync2_r != prev_r) begin
      cnt_next_s = '0;
    end else if (cnt_r != CNT_W'(DEBOUNCE_CYC)) begin
      cnt_next_s = cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_next_s = cnt_r;
    end
    load_s = (cnt_next_s == CNT_W'(DEBOUNCE_CYC - 1));
  end

  // Debounce state and the filtered switch register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r   <= '0;
      cnt_r    <= '0;
      stable_r <= '0;
    end else begin
      prev_r <= sync2_r;
      cnt_r  <= cnt_next_s;
      if (load_s) begin
        stable_r <= sync2_r;
      end
    end
  end
`else
  logic [31:0] cfg_unused_s;
  assign cfg_unused_s = 32'(DEBOUNCE_CYC);

  // Without debounce the stable register simply follows the synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_r <= '0;
    end else begin
      stable_r <= sync2_r;
    end
  end
`endif

  assign sw_stable = stable_r;

endmodule

// File: rtl/io_periph_bank.sv
// Memory-mapped LED/LCD/hex/switch register bank with registered one-cycle reads.
// Optional switch debounce is enabled by defining IO_SW_DEBOUNCE_EN.
module io_periph_bank
  import io_periph_pkg::*;
#(
  parameter int NUM_HEX      = 8,
  parameter int SW_W         = 32,
  parameter int ADDR_W       = 12,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           be_i,
  input  logic                 we_i,
  input  logic                 re_i,
  output logic [31:0]          rdata_o,
  output logic                 rvalid_o,
  output logic                 err_o,
  input  logic [SW_W-1:0]      io_sw_i,
  output logic [31:0]          io_ledr_o,
  output logic [31:0]          io_ledg_o,
  output logic [31:0]          io_lcd_o,
  output logic [NUM_HEX*32-1:0] io_hex_o
);

  localparam logic [ADDR_W-1:0] HEX_END = ADDR_W'(HEX_BASE) + ADDR_W'(4 * NUM_HEX);

  logic [ADDR_W-1:0] word_addr_s;
  logic              addr_lsb_unused_s;
  io_sel_e           sel_s;
  logic [3:0]        hex_idx_s;
  logic [31:0]       hex_rd_s;
  logic [31:0]       rd_data_s;
  logic [SW_W-1:0]   sw_stable_s;

  logic [31:0] ledr_r;
  logic [31:0] ledg_r;
  logic [31:0] lcd_r;
  logic [31:0] hex_r [NUM_HEX];
  logic [31:0] rdata_r;
  logic        rvalid_r;
  logic        err_r;

  assign word_addr_s       = {addr_i[ADDR_W-1:2], 2'b00};
  assign addr_lsb_unused_s = ^addr_i[1:0];

  io_sw_sync #(
    .SW_W         (SW_W),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_sw_sync (
    .clk       (clk_i),
    .rst       (rst_i),
    .sw_async  (io_sw_i),
    .sw_stable (sw_stable_s)
  );

  // Address decode; hex slots at or beyond NUM_HEX fall through to unmapped.
  always_comb begin
    sel_s     = SEL_NONE;
    hex_idx_s = word_addr_s[5:2] - 4'h4;
    if (word_addr_s == ADDR_W'(LEDR_OFF)) begin
      sel_s = SEL_LEDR;
    end else if (word_addr_s == ADDR_W'(LEDG_OFF)) begin
      sel_s = SEL_LEDG;
    end else if (word_addr_s == ADDR_W'(LCD_OFF)) begin
      sel_s = SEL_LCD;
    end else if ((word_addr_s >= ADDR_W'(HEX_BASE)) && (word_addr_s < HEX_END)) begin
      sel_s = SEL_HEX;
    end else if (word_addr_s == ADDR_W'(SW_OFF)) begin
      sel_s = SEL_SW;
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    hex_rd_s = 32'h0;
    for (int k = 0; k < NUM_HEX; k++) begin
      hex_rd_s = hex_rd_s | ({32{hex_idx_s == 4'(k)}} & hex_r[k]);
    end
    case (sel_s)
      SEL_LEDR: rd_data_s = ledr_r;
      SEL_LEDG: rd_data_s = ledg_r;
      SEL_LCD:  rd_data_s = lcd_r;
      SEL_HEX:  rd_data_s = hex_rd_s;
      SEL_SW:   rd_data_s = 32'(sw_stable_s);
      default:  rd_data_s = 32'h0;
    endcase
  end

  // Byte-enabled writes into the output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ledr_r <= 32'h0;
      ledg_r <= 32'h0;
      lcd_r  <= 32'h0;
      for (int k = 0; k < NUM_HEX; k++) begin
        hex_r[k] <= 32'h0;
      end
    end else if (we_i) begin
      case (sel_s)
        SEL_LEDR: ledr_r <= byte_merge(ledr_r, wdata_i, be_i);
        SEL_LEDG: ledg_r <= byte_merge(ledg_r, wdata_i, be_i);
        SEL_LCD:  lcd_r  <= byte_merge(lcd_r, wdata_i, be_i);
        SEL_HEX: begin
          for (int k = 0; k < NUM_HEX; k++) begin
            if (hex_idx_s == 4'(k)) begin
              hex_r[k] <= byte_merge(hex_r[k], wdata_i, be_i);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered read response and error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_r  <= 32'h0;
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      rdata_r  <= re_i ? rd_data_s : 32'h0;
      rvalid_r <= re_i;
      err_r    <= ((re_i | we_i) & (sel_s == SEL_NONE)) | (we_i & (sel_s == SEL_SW));
    end
  end

  assign rdata_o   = rdata_r;
  assign rvalid_o  = rvalid_r;
  assign err_o     = err_r;
  assign io_ledr_o = ledr_r;
  assign io_ledg_o = ledg_r;
  assign io_lcd_o  = lcd_r;

  for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex_out
    assign io_hex_o[32*g +: 32] = hex_r[g];
  end

endmodule

// File: tb/tb_io_periph_bank.sv
// Randomised bench for io_periph_bank against a behavioural register-map model,
// plus directed literal checks of the headline scenarios.
module tb_io_periph_bank;

  localparam int NUM_HEX = 4;
  localparam int SW_W    = 8;
  localparam int ADDR_W  = 12;
  localparam int DEB     = 16;
`ifdef IO_SW_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
  localparam int SW_LAT = DEB + 2;
`else
  localparam bit DEB_ON = 1'b0;
  localparam int SW_LAT = 3;
`endif

  logic                  clk = 1'b0;
  logic                  rst_i = 1'b0;
  logic [ADDR_W-1:0]     addr_i = '0;
  logic [31:0]           wdata_i = 32'h0;
  logic [3:0]            be_i = 4'h0;
  logic                  we_i = 1'b0;
  logic                  re_i = 1'b0;
  logic [31:0]           rdata_o;
  logic                  rvalid_o;
  logic                  err_o;
  logic [SW_W-1:0]       io_sw_i = '0;
  logic [31:0]           io_ledr_o, io_ledg_o, io_lcd_o;
  logic [NUM_HEX*32-1:0] io_hex_o;

  io_periph_bank #(
    .NUM_HEX(NUM_HEX), .SW_W(SW_W), .ADDR_W(ADDR_W), .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
    .we_i(we_i), .re_i(re_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .err_o(err_o),
    .io_sw_i(io_sw_i), .io_ledr_o(io_ledr_o), .io_ledg_o(io_ledg_o),
    .io_lcd_o(io_lcd_o), .io_hex_o(io_hex_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]     m_ledr, m_ledg, m_lcd;
  logic [31:0]     m_hex [NUM_HEX];
  logic [SW_W-1:0] m_hist [0:DEB];
  logic [SW_W-1:0] m_stable;
  logic            e_rvalid, e_err;
  logic [31:0]     e_rdata;

  // Region of a byte address: 0 LEDR, 1 LEDG, 2 LCD, 3 HEX, 4 SW, 5 unmapped.
  function automatic int m_kind(input logic [ADDR_W-1:0] a);
    int wa;
    wa = int'(a) / 4 * 4;
    if (wa == 0) return 0;
    if (wa == 4) return 1;
    if (wa == 8) return 2;
    if (wa >= 16 && wa < 16 + 4 * NUM_HEX) return 3;
    if (wa == 256) return 4;
    return 5;
  endfunction

  function automatic int m_hidx(input logic [ADDR_W-1:0] a);
    return (int'(a) / 4) - 4;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
    case (m_kind(a))
      0: return m_ledr;
      1: return m_ledg;
      2: return m_lcd;
      3: return m_hex[m_hidx(a)];
      4: return 32'(m_stable);
      default: return 32'h0;
    endcase
  endfunction

  // New switch value once the pipe has seen DEB identical samples (or any sample, no debounce).
  function automatic logic [SW_W-1:0] m_sw_next();
    if (!DEB_ON) return m_hist[1];
    for (int i = 2; i <= DEB; i++) begin
      if (m_hist[i] != m_hist[1]) return m_stable;
    end
    return m_hist[1];
  endfunction

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      m_ledr <= 32'h0; m_ledg <= 32'h0; m_lcd <= 32'h0;
      for (int k = 0; k < NUM_HEX; k++) m_hex[k] <= 32'h0;
      for (int i = 0; i <= DEB; i++) m_hist[i] <= '0;
      m_stable <= '0;
      e_rvalid <= 1'b0; e_err <= 1'b0; e_rdata <= 32'h0;
    end else begin
      e_rvalid <= re_i;
      e_rdata  <= re_i ? m_read(addr_i) : 32'h0;
      e_err    <= ((re_i || we_i) && m_kind(addr_i) == 5) || (we_i && m_kind(addr_i) == 4);
      if (we_i && m_kind(addr_i) == 0) m_ledr <= m_merge(m_ledr, wdata_i, be_i);
      if (we_i && m_kind(addr_i) == 1) m_ledg <= m_merge(m_ledg, wdata_i, be_i);
      if (we_i && m_kind(addr_i) == 2) m_lcd  <= m_merge(m_lcd, wdata_i, be_i);
      for (int k = 0; k < NUM_HEX; k++) begin
        if (we_i && m_kind(addr_i) == 3 && m_hidx(addr_i) == k)
          m_hex[k] <= m_merge(m_hex[k], wdata_i, be_i);
      end
      m_hist[0] <= io_sw_i;
      for (int i = 1; i <= DEB; i++) m_hist[i] <= m_hist[i-1];
      m_stable <= m_sw_next();
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    check("ledr", 64'(io_ledr_o), 64'(m_ledr));
    check("ledg", 64'(io_ledg_o), 64'(m_ledg));
    check("lcd",  64'(io_lcd_o),  64'(m_lcd));
    for (int k = 0; k < NUM_HEX; k++)
      check($sformatf("hex%0d", k), 64'(io_hex_o[32*k +: 32]), 64'(m_hex[k]));
    check("rvalid", 64'(rvalid_o), 64'(e_rvalid));
    check("err", 64'(err_o), 64'(e_err));
    if (e_rvalid === 1'b1) check("rdata", 64'(rdata_o), 64'(e_rdata));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    addr_i = a; wdata_i = d; be_i = be; we_i = 1'b1; re_i = 1'b0;
    cyc();
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    addr_i = a; re_i = 1'b1; we_i = 1'b0;
    cyc();
    re_i = 1'b0;
  endtask

  logic [ADDR_W-1:0] tbl [12];
  int hold;

  initial begin
    tbl = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
            12'h01C, 12'h020, 12'h04C, 12'h100, 12'h104, 12'h900};
    #1 rst_i = 1'b1;
    repeat (3) cyc();
    rst_i = 1'b0;
    cyc();

    // 1: reset clears pre-written outputs
    wr(12'h000, 32'hA5A5_0001, 4'hF);
    wr(12'h004, 32'h1234_5678, 4'hF);
    wr(12'h008, 32'hCAFE_F00D, 4'hF);
    wr(12'h010, 32'h0BAD_BEEF, 4'hF);
    check("pre_ledr", 64'(io_ledr_o), 64'h0000_0000_A5A5_0001);
    rst_i = 1'b1;
    cyc();
    check("rst_ledr", 64'(io_ledr_o), 64'h0);
    check("rst_ledg", 64'(io_ledg_o), 64'h0);
    check("rst_lcd",  64'(io_lcd_o),  64'h0);
    check("rst_hex",  64'(io_hex_o[63:0]), 64'h0);
    check("rst_rvalid", 64'(rvalid_o), 64'h0);
    rst_i = 1'b0;
    cyc();
    rd(12'h000);
    check("rd0_rvalid", 64'(rvalid_o), 64'h1);
    check("rd0_rdata", 64'(rdata_o), 64'h0);

    // 2: partial byte write
    wr(12'h004, 32'hDEAD_BEEF, 4'b0101);
    check("ledg_be", 64'(io_ledg_o), 64'h0000_0000_00AD_00EF);
    rd(12'h004);
    check("ledg_rd", 64'(rdata_o), 64'h0000_0000_00AD_00EF);

    // 3: last hex slot mapped, first slot past NUM_HEX unmapped
    wr(12'h01C, 32'h1234_5678, 4'hF);
    check("hex3", 64'(io_hex_o[127:96]), 64'h0000_0000_1234_5678);
    wr(12'h020, 32'hFFFF_FFFF, 4'hF);
    check("hex_oob_err", 64'(err_o), 64'h1);
    check("hex_oob_nochg", 64'(io_hex_o[127:64]), 64'h1234_5678_0000_0000);
    rd(12'h020);
    check("oob_rd_data", 64'(rdata_o), 64'h0);
    check("oob_rd_err", 64'(err_o), 64'h1);
    check("oob_rd_valid", 64'(rvalid_o), 64'h1);

    // 4: same-cycle write and read returns the old value
    wr(12'h008, 32'h0000_0011, 4'hF);
    addr_i = 12'h008; wdata_i = 32'h0000_0022; be_i = 4'hF; we_i = 1'b1; re_i = 1'b1;
    cyc();
    we_i = 1'b0; re_i = 1'b0;
    check("rw_old", 64'(rdata_o), 64'h11);
    rd(12'h008);
    check("rw_new", 64'(rdata_o), 64'h22);

    // 5: switch path latency (and glitch rejection with debounce)
    io_sw_i = '0;
    repeat (DEB + 5) cyc();
    addr_i = 12'h100; re_i = 1'b1;
    io_sw_i = 8'h01;
    repeat (5) cyc();
    io_sw_i = 8'h00;
    for (int k = 0; k < 25; k++) begin
      cyc();
      if (DEB_ON) check("sw_glitch", 64'(rdata_o), 64'h0);
    end
    io_sw_i = 8'h5A;
    for (int k = 1; k <= SW_LAT + 1; k++) begin
      cyc();
      if (k == SW_LAT) check("sw_before", 64'(rdata_o), 64'h0);
      if (k == SW_LAT + 1) check("sw_after", 64'(rdata_o), 64'h5A);
    end
    re_i = 1'b0;
    cyc();

    // 6: reset during a pending read drops the response
    addr_i = 12'h000; re_i = 1'b1;
    @(negedge clk);
    #1 rst_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("rst_mid_rvalid", 64'(rvalid_o), 64'h0);
    end
    re_i = 1'b0; rst_i = 1'b0;
    cyc();
    check("post_rst_rvalid", 64'(rvalid_o), 64'h0);
    check("post_rst_ledg", 64'(io_ledg_o), 64'h0);
    check("post_rst_lcd", 64'(io_lcd_o), 64'h0);

    // Random traffic against the model
    hold = 0;
    for (int n = 0; n < 2500; n++) begin
      addr_i  = tbl[$urandom_range(0, 11)] | ADDR_W'($urandom_range(0, 3));
      we_i    = ($urandom_range(0, 2) == 0);
      re_i    = ($urandom_range(0, 1) == 1);
      wdata_i = $urandom;
      be_i    = 4'($urandom_range(0, 15));
      if (hold == 0) begin
        io_sw_i = SW_W'($urandom);
        hold = $urandom_range(1, 40);
      end else begin
        hold--;
      end
      rst_i = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst_i = 1'b0; we_i = 1'b0; re_i = 1'b0;
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
